// File: rtl/cpu_run_pkg.sv
// Shared constants for the CPU run/halt/step controller.
// Mode encoding as seen on the mode output.
package cpu_run_pkg;
  localparam logic [1:0] MODE_HALT = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;
  localparam int CNT_W = 32;
endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stability debouncer and
// one-cycle press event on the debounced 1 -> 0 transition.
module btn_debounce
  import cpu_run_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Count consecutive cycles the synced level disagrees
    if (sync2_q != deb_q) begin
      if (cnt_q == LAST) begin
        deb_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step scheduler driving the CPU clock enable.
// Optional breakpoint halt: define CPU_RUN_CTRL_BREAK_EN.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int DIV_LOG2        = 1,
  parameter bit RESET_RUN       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode_n,
  input  logic             btn_step_n,
`ifdef CPU_RUN_CTRL_BREAK_EN
  input  logic [31:0]      pc,
  input  logic [31:0]      brk_addr,
  input  logic             brk_valid,
`endif
  output logic             cpu_ce,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_count,
  output logic             run_led
);
  localparam int DW = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'((1 << DIV_LOG2) - 1);
  localparam logic [1:0] RST_MODE = RESET_RUN ? MODE_RUN : MODE_HALT;

  logic             mode_ev, step_ev;
  logic [1:0]       mode_q, mode_d;
  logic             ce_q, ce_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             due, brk_hit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .btn_n(btn_mode_n), .press(mode_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .rst(rst), .btn_n(btn_step_n), .press(step_ev)
  );

`ifdef CPU_RUN_CTRL_BREAK_EN
  logic first_q, first_d;
  // The first due pulse after entering RUN skips the compare
  assign brk_hit = brk_valid && (pc == brk_addr) && !first_q;
`else
  assign brk_hit = 1'b0;
`endif

  assign due = (div_q == DIV_LAST);

  always_comb begin
    mode_d = mode_q;
    ce_d   = 1'b0;
    div_d  = div_q;
`ifdef CPU_RUN_CTRL_BREAK_EN
    first_d = first_q;
`endif
    unique case (1'b1)
      (mode_q == MODE_HALT): begin
        if (mode_ev) begin
          mode_d = MODE_RUN;
          div_d  = '0;
`ifdef CPU_RUN_CTRL_BREAK_EN
          first_d = 1'b1;
`endif
        end else if (step_ev) begin
          mode_d = MODE_STEP;
          ce_d   = 1'b1;
        end
      end
      (mode_q == MODE_STEP): mode_d = MODE_HALT;
      (mode_q == MODE_RUN): begin
        if (mode_ev) begin
          mode_d = MODE_HALT;
        end else begin
          div_d = due ? '0 : div_q + 1'b1;
          if (due && brk_hit) begin
            mode_d = MODE_HALT;
          end else if (due) begin
            ce_d = 1'b1;
`ifdef CPU_RUN_CTRL_BREAK_EN
            first_d = 1'b0;
`endif
          end
        end
      end
      default: mode_d = MODE_HALT;
    endcase
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, ce_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= RST_MODE;
      ce_q   <= 1'b0;
      div_q  <= '0;
      cnt_q  <= '0;
`ifdef CPU_RUN_CTRL_BREAK_EN
      first_q <= 1'b1;
`endif
    end else begin
      mode_q <= mode_d;
      ce_q   <= ce_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
`ifdef CPU_RUN_CTRL_BREAK_EN
      first_q <= first_d;
`endif
    end
  end

  assign cpu_ce      = ce_q;
  assign mode        = mode_q;
  assign cycle_count = cnt_q;
  assign run_led     = (mode_q == MODE_RUN);
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized + directed bench for cpu_run_ctrl against a
// behavioural model of the button/mode/pulse rules.
module tb_cpu_run_ctrl;
  localparam int D   = 4;
  localparam int DL2 = 1;
  localparam int N   = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode_n = 1'b1;
  logic        btn_step_n = 1'b1;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic [31:0] cycle_count;
  logic        run_led;
`ifdef CPU_RUN_CTRL_BREAK_EN
  logic [31:0] pc = 32'h0;
  logic [31:0] brk_addr = 32'h40;
  logic        brk_valid = 1'b1;
`endif

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(D), .DIV_LOG2(DL2), .RESET_RUN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_mode_n(btn_mode_n), .btn_step_n(btn_step_n),
`ifdef CPU_RUN_CTRL_BREAK_EN
    .pc(pc), .brk_addr(brk_addr), .brk_valid(brk_valid),
`endif
    .cpu_ce(cpu_ce), .mode(mode),
    .cycle_count(cycle_count), .run_led(run_led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model state
  logic [1:0]  m_mode = 2'd1;
  bit          m_ce = 0;
  logic [31:0] m_count = 0;
  int          m_age = 0;
  bit          m_dly[2][2];
  bit          m_deb[2];
  int          m_run[2];
  bit          m_ev[2];
`ifdef CPU_RUN_CTRL_BREAK_EN
  bit          m_first = 1;
`endif

  initial begin
    bit mev, sev, ce, sy;
    bit raw[2];
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 2'd1; m_ce = 0; m_count = 0; m_age = 0;
`ifdef CPU_RUN_CTRL_BREAK_EN
        m_first = 1;
`endif
        for (int b = 0; b < 2; b++) begin
          m_dly[b][0] = 1; m_dly[b][1] = 1;
          m_deb[b] = 1; m_run[b] = 0; m_ev[b] = 0;
        end
      end else begin
        mev = m_ev[0]; sev = m_ev[1]; ce = 0;
        if (m_mode == 2'd0) begin
          if (mev) begin
            m_mode = 2'd1; m_age = 0;
`ifdef CPU_RUN_CTRL_BREAK_EN
            m_first = 1;
`endif
          end else if (sev) begin
            m_mode = 2'd2; ce = 1;
          end
        end else if (m_mode == 2'd2) begin
          m_mode = 2'd0;
        end else if (mev) begin
          m_mode = 2'd0;
        end else begin
          m_age++;
          if (m_age % N == 0) begin
`ifdef CPU_RUN_CTRL_BREAK_EN
            if (brk_valid && pc == brk_addr && !m_first)
              m_mode = 2'd0;
            else begin
              ce = 1; m_first = 0;
            end
`else
            ce = 1;
`endif
          end
        end
        m_ce = ce;
        m_count = m_count + 32'(ce);
        raw[0] = btn_mode_n; raw[1] = btn_step_n;
        for (int b = 0; b < 2; b++) begin
          sy = m_dly[b][1];
          m_ev[b] = 0;
          if (sy != m_deb[b]) begin
            m_run[b]++;
            if (m_run[b] == D) begin
              m_deb[b] = sy; m_ev[b] = !sy; m_run[b] = 0;
            end
          end else begin
            m_run[b] = 0;
          end
          m_dly[b][1] = m_dly[b][0];
          m_dly[b][0] = raw[b];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("mode", {30'b0, mode}, {30'b0, m_mode});
        chk("cpu_ce", {31'b0, cpu_ce}, {31'b0, m_ce});
        chk("cycle_count", cycle_count, m_count);
        chk("run_led", {31'b0, run_led},
            {31'b0, m_mode == 2'd1});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nce, nstep, t_run, t_ce;
    logic [31:0] snap;
    tick(3);
    chk_en = 1;
    chk("rst_mode", {30'b0, mode}, 32'd1);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_ce", {31'b0, cpu_ce}, 32'd0);
    rst = 0;
    tick(10);
    chk("run_count10", cycle_count, 32'd5);

    for (int i = 0; i < 3; i++) begin
      btn_mode_n = 0; tick(2);
      btn_mode_n = 1; tick(3);
    end
    tick(8);
    chk("glitch_mode", {30'b0, mode}, 32'd1);
    btn_mode_n = 0; tick(10);
    chk("halt_mode", {30'b0, mode}, 32'd0);
    btn_mode_n = 1;
    nce = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1); nce += int'(cpu_ce);
    end
    chk("halt_no_ce", nce, 32'd0);

    snap = m_count;
    btn_step_n = 0;
    nce = 0; nstep = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) btn_step_n = 1;
      tick(1);
      if (mode == 2'd2) nstep++;
      if (cpu_ce && mode == 2'd2) nce++;
    end
    chk("step_cycles", nstep, 32'd1);
    chk("step_ce", nce, 32'd1);
    chk("step_mode", {30'b0, mode}, 32'd0);
    chk("step_count", cycle_count, snap + 32'd1);

    btn_mode_n = 0; btn_step_n = 0;
    nstep = 0; t_run = -1; t_ce = -1;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) begin btn_mode_n = 1; btn_step_n = 1; end
      tick(1);
      if (mode == 2'd2) nstep++;
      if (t_run < 0 && mode == 2'd1) t_run = i;
      if (t_ce < 0 && cpu_ce) t_ce = i;
    end
    chk("simul_no_step", nstep, 32'd0);
    chk("simul_mode", {30'b0, mode}, 32'd1);
    chk("simul_first_ce", t_ce - t_run, 32'd2);
    btn_mode_n = 0; tick(8);
    btn_mode_n = 1; tick(10);
    chk("halt2_mode", {30'b0, mode}, 32'd0);

    #1;
    force dut.cnt_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    tick(1); #1;
    release dut.cnt_q;
    tick(2);
    btn_step_n = 0; tick(8);
    btn_step_n = 1; tick(10);
    chk("wrap_count", cycle_count, 32'd0);

`ifdef CPU_RUN_CTRL_BREAK_EN
    btn_mode_n = 0; tick(8);
    btn_mode_n = 1; tick(6);
    snap = m_count;
    pc = 32'h40; tick(4);
    chk("brk_mode", {30'b0, mode}, 32'd0);
    chk("brk_count", cycle_count, snap);
    btn_mode_n = 0; tick(8);
    btn_mode_n = 1;
    snap = m_count;
    nce = 0;
    for (int i = 0; i < 8 && nce == 0; i++) begin
      tick(1); nce += int'(cpu_ce);
    end
    chk("resume_pulse", nce, 32'd1);
    pc = 32'h44; tick(6);
    chk("resume_mode", {30'b0, mode}, 32'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) btn_mode_n = ~btn_mode_n;
      if ($urandom_range(0, 7) == 0) btn_step_n = ~btn_step_n;
`ifdef CPU_RUN_CTRL_BREAK_EN
      if ($urandom_range(0, 5) == 0)
        pc = $urandom_range(0, 1) ? 32'h40 : 32'h44;
      brk_valid = ($urandom_range(0, 3) != 0);
`endif
      tick(1);
    end
    rst = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
